sonar_range_filter: RTL and testbench
=====================================

# sonar_range_filter

Downstream consumer of the MAXSONAR PWM-to-distance stage. Captures each new 8-bit inch reading, rejects single-sample spikes with a 3-tap running median, and drives a hysteretic obstacle flag for the drive controller. A watchdog flags the sensor stale when readings stop arriving. Both stale and power-up conditions default to obstacle asserted, so the robot stops rather than drives.

## Interface
Parameters:
- NEAR_IN, 12: obstacle sets when the filtered distance is <= NEAR_IN inches.
- FAR_IN, 15: obstacle clears when the filtered distance is >= FAR_IN inches. Requires FAR_IN > NEAR_IN.
- TIMEOUT_CLKS, 10000000: cycles without a new reading before stale (100 ms at 100 MHz). Range 1..2^32-1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- distance  in  8  upstream reading in inches; valid in the first cycle new_dist is high.
- new_dist  in  1  upstream level; a low-to-high transition marks a new reading.
- dist_filt  out  8  median-filtered distance in inches.
- filt_valid  out  1  one-cycle pulse when dist_filt updates.
- obstacle  out  1  hysteretic proximity flag; fail-safe high.
- stale  out  1  high when no valid filtered output exists (after reset or timeout).

## Operation
- Strobe:
  - strb = new_dist & ~nd_prev, where nd_prev is new_dist registered. nd_prev resets to 1, so a level already high at reset release is ignored.
  - Only the first high cycle counts. distance is sampled in that cycle and ignored in all other cycles.
- Window: registers s0 (newest), s1, s2.
  - On strb: s2<=s1, s1<=s0, s0<=distance.
- Fill FSM: EMPTY -> ONE -> TWO -> FULL, advancing one state per strb. FULL stays FULL on strb.
- Output on strb:
  - In state TWO or FULL, dist_filt <= median(distance, s0, s1) = max(min(a,b), min(max(a,b),c)), 8-bit unsigned. No arithmetic overflow is possible.
  - filt_valid <= 1 for one cycle.
  - In EMPTY or ONE, no output.
- Obstacle update, only on cycles where filt_valid is being set:
  - Set to 1 if median <= NEAR_IN.
  - Else clear to 0 if median >= FAR_IN.
  - Else hold.
- Stale:
  - On any filt_valid, stale <= 0.
- Watchdog: 32-bit counter wd.
  - strb: wd <= 0.
  - Otherwise wd increments.
  - When wd == TIMEOUT_CLKS-1 and no strb: stale <= 1, obstacle <= 1, FSM <= EMPTY, wd <= 0. The window contents become don't-care.
  - strb and timeout in the same cycle: strb wins, no timeout.
- Reset (async, any time including mid-fill): FSM=EMPTY, s0..s2=0, wd=0, nd_prev=1, dist_filt=0, filt_valid=0, obstacle=1, stale=1.

## Timing
- Cycle T = first cycle with new_dist=1 after a cycle with new_dist=0.
- dist_filt, filt_valid and obstacle update on the edge ending T, so they are visible in T+1. Latency is 1 clock.
- filt_valid is never high in two consecutive cycles. Upstream readings are at least tens of milliseconds apart, but the block must handle strobes 2 cycles apart, which is the minimum toggle period.
- After reset or timeout, the first filt_valid follows the third strb.
- stale rises on the edge at which wd equals TIMEOUT_CLKS-1, i.e. TIMEOUT_CLKS cycles after the last strb edge.
- stale falls together with the first subsequent filt_valid.

## Test plan
- Reset:
  - Stimulus: assert reset_n=0 mid-cycle with inputs toggling.
  - Required: immediately (asynchronously) obstacle=1, stale=1, filt_valid=0, dist_filt=0.
  - After release, with new_dist held high from before release: no filt_valid.
- Warm-up:
  - Stimulus: readings 40, 42, 41.
  - Required: no pulse after the first two readings. After the third, exactly one filt_valid, dist_filt=41, obstacle=0, stale=0.
- Spike rejection:
  - Stimulus: window 40, 41, then reading 5.
  - Required: dist_filt=40, obstacle stays 0.
  - Then: reading 6 -> dist_filt=6, obstacle=1.
- Hysteresis:
  - Stimulus: steady 12s.
  - Required: obstacle=1. Readings of 14 hold obstacle=1. Readings of 15 clear it to 0 on the second 15, when the median becomes 15.
- Level strobe:
  - Stimulus: new_dist held high 50 cycles while distance changes every cycle.
  - Required: only the value from the first high cycle enters the window; exactly one filt_valid.
- Watchdog (bench with TIMEOUT_CLKS=100):
  - Gap of 100 cycles -> stale=1, obstacle=1, and 3 further readings are needed before filt_valid.
  - strb arriving exactly in the timeout cycle -> stale stays 0.
  - Reset asserted in state TWO -> the next reading does not produce filt_valid.

Source files
------------

// File: rtl/sonar_range_filter.sv
// Sonar range filter: edge-strobed capture, 3-tap running median, hysteretic
// obstacle flag and a staleness watchdog. Power-up and stale both fail safe (obstacle high).
module sonar_range_filter #(
    parameter int unsigned NEAR_IN      = 12,
    parameter int unsigned FAR_IN       = 15,
    parameter int unsigned TIMEOUT_CLKS = 10000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] distance,
    input  logic       new_dist,
    output logic [7:0] dist_filt,
    output logic       filt_valid,
    output logic       obstacle,
    output logic       stale
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} fill_t;

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CLKS - 1);

    fill_t       fill;
    logic        nd_prev;
    logic [7:0]  s0;
    logic [7:0]  s1;
    logic [31:0] wd;
    logic        strb;
    logic        emit;
    logic [7:0]  med;

    function automatic logic [7:0] median3(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] mid;
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        mid = (hi < c) ? hi : c;
        return (lo > mid) ? lo : mid;
    endfunction

    // The incoming sample is the third tap, so only the two previous samples are stored.
    assign strb = new_dist & ~nd_prev;
    assign emit = strb && (fill == TWO || fill == FULL);
    assign med  = median3(distance, s0, s1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill       <= EMPTY;
            nd_prev    <= 1'b1;
            s0         <= '0;
            s1         <= '0;
            wd         <= '0;
            dist_filt  <= '0;
            filt_valid <= 1'b0;
            obstacle   <= 1'b1;
            stale      <= 1'b1;
        end else begin
            nd_prev    <= new_dist;
            filt_valid <= 1'b0;
            if (strb) begin
                wd <= '0;
                s1 <= s0;
                s0 <= distance;
                fill <= (fill == FULL) ? FULL : fill_t'(fill + 2'd1);
                if (emit) begin
                    dist_filt  <= med;
                    filt_valid <= 1'b1;
                    stale      <= 1'b0;
                    if ({24'd0, med} <= NEAR_IN) begin
                        obstacle <= 1'b1;
                    end else if ({24'd0, med} >= FAR_IN) begin
                        obstacle <= 1'b0;
                    end
                end
            end else if (wd == WD_LAST) begin
                // Sensor went quiet: fail safe and demand a fresh full window.
                stale    <= 1'b1;
                obstacle <= 1'b1;
                fill     <= EMPTY;
                wd       <= '0;
            end else begin
                wd <= wd + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sonar_range_filter.sv
// Randomized scoreboard bench for sonar_range_filter against a timestamped
// reading-history model (TIMEOUT_CLKS shortened to 100).
module tb_sonar_range_filter;

    localparam int NEAR = 12;
    localparam int FAR  = 15;
    localparam int TO   = 100;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] distance;
    logic       new_dist;
    logic [7:0] dist_filt;
    logic       filt_valid;
    logic       obstacle;
    logic       stale;

    sonar_range_filter #(.NEAR_IN(NEAR), .FAR_IN(FAR), .TIMEOUT_CLKS(TO)) dut (
        .clk(clk), .reset_n(reset_n), .distance(distance), .new_dist(new_dist),
        .dist_filt(dist_filt), .filt_valid(filt_valid), .obstacle(obstacle), .stale(stale)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {int at; int d; int obst;} exp_t;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: readings since the last reset/timeout, time of last reading.
    int win[$];
    int last_ref;
    int m_obst;
    int m_stale;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void m_time(input int n);
        while (n - last_ref >= TO) begin
            win.delete();
            m_obst   = 1;
            m_stale  = 1;
            last_ref += TO;
        end
    endfunction

    function automatic void m_strobe(input int d, input int s);
        int   v[3];
        exp_t e;
        m_time(s - 1);
        last_ref = s;
        win.push_front(d);
        if (win.size() > 3) void'(win.pop_back());
        if (win.size() == 3) begin
            v[0] = win[0]; v[1] = win[1]; v[2] = win[2];
            v.sort();
            if (v[1] <= NEAR) m_obst = 1;
            else if (v[1] >= FAR) m_obst = 0;
            m_stale = 0;
            e.at = s; e.d = v[1]; e.obst = m_obst;
            sb.push_back(e);
        end
    endfunction

    // Monitor: every pulse must match the head of the scoreboard at its scheduled edge.
    exp_t cur;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (sb.size() > 0 && sb[0].at == edge_cnt) begin
                cur = sb.pop_front();
                chk("pulse_valid", int'(filt_valid), 1);
                chk("pulse_dist", int'(dist_filt), cur.d);
                chk("pulse_obstacle", int'(obstacle), cur.obst);
                chk("pulse_stale", int'(stale), 0);
            end else if (filt_valid) begin
                chk("spurious_valid", int'(filt_valid), 0);
            end
        end
    end

    task automatic send(input int d, input int hold, input int gap);
        @(negedge clk);
        distance = d[7:0];
        new_dist = 1'b1;
        m_strobe(d, edge_cnt + 1);
        repeat (hold - 1) begin
            @(negedge clk);
            distance = 8'($urandom);
        end
        @(negedge clk);
        new_dist = 1'b0;
        distance = 8'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic check_state(input string nm);
        m_time(edge_cnt);
        chk({nm, "_stale"}, int'(stale), m_stale);
        chk({nm, "_obstacle"}, int'(obstacle), m_obst);
    endtask

    task automatic check_reset_values(input string nm);
        chk({nm, "_obstacle"}, int'(obstacle), 1);
        chk({nm, "_stale"}, int'(stale), 1);
        chk({nm, "_filt_valid"}, int'(filt_valid), 0);
        chk({nm, "_dist_filt"}, int'(dist_filt), 0);
    endtask

    task automatic model_reset();
        sb.delete();
        win.delete();
        m_obst  = 1;
        m_stale = 1;
    endtask

    // Asynchronous reset asserted mid-cycle, right after an active edge.
    task automatic do_reset(input logic level_at_release);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_reset");
        repeat (3) begin
            @(negedge clk);
            new_dist = ~new_dist;
            distance = 8'($urandom);
        end
        @(negedge clk);
        new_dist = level_at_release;
        reset_n  = 1'b1;
        last_ref = edge_cnt;
    endtask

    initial begin
        reset_n  = 1'b0;
        new_dist = 1'b1;
        distance = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset_n  = 1'b1;
        last_ref = edge_cnt;
        // Level already high at release must not count as a reading.
        repeat (5) begin
            @(negedge clk);
            distance = 8'($urandom);
        end
        new_dist = 1'b0;
        check_state("held_high");

        // Warm-up
        send(40, 2, 3);
        send(42, 1, 4);
        send(41, 3, 2);
        check_state("warmup");

        // Spike rejection
        send(40, 1, 2);
        send(41, 1, 2);
        send(5, 1, 2);
        send(6, 1, 2);

        // Hysteresis band
        repeat (3) send(12, 1, 1);
        repeat (3) send(14, 1, 1);
        repeat (2) send(15, 1, 1);
        check_state("hyst");

        // Long level: only the first cycle is sampled
        send(33, 50, 3);

        // Randomized readings, strobes as close as 2 cycles apart
        for (int i = 0; i < 60; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(5, 22));
            send(d, int'($urandom_range(1, 3)), int'($urandom_range(1, 4)));
        end

        // Watchdog expiry then re-fill
        send(20, 1, 150);
        check_state("timeout");
        send(30, 1, 2);
        send(31, 1, 2);
        send(32, 1, 2);
        check_state("refill");

        // Readings exactly TIMEOUT_CLKS apart: strobe wins
        repeat (3) send(int'($urandom_range(8, 20)), 1, 99);
        check_state("boundary_100");
        // One cycle later than that: timeout first
        repeat (4) send(int'($urandom_range(8, 20)), 1, 100);
        check_state("boundary_101");

        // Reset mid-fill (state TWO)
        send(25, 1, 3);
        send(26, 1, 3);
        do_reset(1'b0);
        send(27, 1, 3);
        send(28, 1, 3);
        send(29, 1, 3);
        check_state("post_reset_fill");

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
